// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency counter gate sequencer.
// Sequencer state encoding and the gate_sel clamp helper live here.
package freq_meter_pkg;

  localparam int GATE_SEL_W       = 2;
  localparam int DEF_MAX_GATE_SEL = 3;
  localparam int DEF_SYNC_STAGES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } seq_state_t;

  function automatic logic [GATE_SEL_W-1:0] clamp_sel(
    input logic [GATE_SEL_W-1:0] sel,
    input logic [GATE_SEL_W-1:0] max_sel
  );
    return (sel > max_sel) ? max_sel : sel;
  endfunction

endpackage

// File: rtl/freq_gate_sequencer_if.sv
// Control/status bundle between the top-level config and the gate sequencer.
// master drives start/config and the fin-domain overflow; slave is the sequencer.
interface freq_gate_sequencer_if;
  import freq_meter_pkg::*;

  logic                  start;
  logic                  mode_cont;
  logic                  hold;
  logic [GATE_SEL_W-1:0] gate_sel;
  logic                  ovf_in;

  logic                  count_en;
  logic                  latch_en;
  logic                  clear;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [GATE_SEL_W-1:0] gate_used;

  modport master (
    output start, mode_cont, hold, gate_sel, ovf_in,
    input  count_en, latch_en, clear, busy, done, overflow, gate_used
  );

  modport slave (
    input  start, mode_cont, hold, gate_sel, ovf_in,
    output count_en, latch_en, clear, busy, done, overflow, gate_used
  );

endinterface

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with asynchronous active-low reset.
// Reusable for any slow flag crossing from the fin domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/freq_gate_sequencer.sv
// Gate/latch/clear sequencer for the 8-decade frequency counter chain.
// All outputs are registered decodes of the next state.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; busy low
//   ST_CLEAR | one tick of clear to every decade, gate length captured
//   ST_GATE  | count_en high for 2^gate_sel_q ticks
//   ST_LATCH | latch_en in first tick, then wait out the ovf synchroniser
module freq_gate_sequencer
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int GATE_CNT_W   = 4,
  parameter int MAX_GATE_SEL = DEF_MAX_GATE_SEL
) (
  input logic                  clk_1Hz,
  input logic                  rst_n,
  freq_gate_sequencer_if.slave bus
);

  localparam int LAT_W = $clog2(SYNC_STAGES);
  localparam logic [LAT_W-1:0]      LAT_LOAD = LAT_W'(SYNC_STAGES - 1);
  localparam logic [GATE_SEL_W-1:0] MAX_SEL  = GATE_SEL_W'(MAX_GATE_SEL);

  seq_state_t            state, state_nxt;
  logic [GATE_SEL_W-1:0] gate_sel_q, gate_sel_nxt;
  logic [GATE_CNT_W-1:0] gate_cnt, gate_cnt_nxt, gate_load;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
  logic                  latch_en_nxt, done_nxt;
  logic                  ovf_sync;

  logic                  count_en_q, latch_en_q, clear_q, busy_q, done_q, overflow_q;
  logic [GATE_SEL_W-1:0] gate_used_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ovf_sync (
    .clk   (clk_1Hz),
    .rst_n (rst_n),
    .d     (bus.ovf_in),
    .q     (ovf_sync)
  );

  assign gate_load = (GATE_CNT_W'(1) << gate_sel_q) - GATE_CNT_W'(1);

  always_comb begin
    state_nxt    = state;
    gate_sel_nxt = gate_sel_q;
    gate_cnt_nxt = gate_cnt;
    lat_cnt_nxt  = lat_cnt;
    latch_en_nxt = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt    = ST_CLEAR;
          gate_sel_nxt = clamp_sel(bus.gate_sel, MAX_SEL);
        end
      end
      ST_CLEAR: begin
        state_nxt    = ST_GATE;
        gate_cnt_nxt = gate_load;
      end
      ST_GATE: begin
        if (gate_cnt == '0) begin
          state_nxt    = ST_LATCH;
          lat_cnt_nxt  = LAT_LOAD;
          latch_en_nxt = 1'b1;
        end else begin
          gate_cnt_nxt = gate_cnt - GATE_CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (lat_cnt == '0) begin
          done_nxt = 1'b1;
          // mode_cont and hold only matter here, so mid-gate changes finish the current result
          if (bus.mode_cont && !bus.hold) begin
            state_nxt    = ST_CLEAR;
            gate_sel_nxt = clamp_sel(bus.gate_sel, MAX_SEL);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gate_sel_q  <= '0;
      gate_cnt    <= '0;
      lat_cnt     <= '0;
      count_en_q  <= 1'b0;
      latch_en_q  <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      gate_used_q <= '0;
    end else begin
      state      <= state_nxt;
      gate_sel_q <= gate_sel_nxt;
      gate_cnt   <= gate_cnt_nxt;
      lat_cnt    <= lat_cnt_nxt;
      count_en_q <= (state_nxt == ST_GATE);
      latch_en_q <= latch_en_nxt;
      clear_q    <= (state_nxt == ST_CLEAR);
      busy_q     <= (state_nxt != ST_IDLE);
      done_q     <= done_nxt;
      if (done_nxt) begin
        overflow_q  <= ovf_sync;
        gate_used_q <= gate_sel_q;
      end
    end
  end

  assign bus.count_en  = count_en_q;
  assign bus.latch_en  = latch_en_q;
  assign bus.clear     = clear_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.gate_used = gate_used_q;

endmodule
